// File: rtl/game_ctrl_multi.sv
// ---------------------------------------------------------------------------
// game_ctrl_multi
//
// Game-flow controller for the spaceship arcade. It walks through idle,
// arming, play, hit-hold and game-over phases based on the USB keycode
// report. During play it issues numbered shots from a magazine of
// NUM_BULLETS on each press/release of the selected player's fire key.
//
// Optional feature macro: GAME_CTRL_RELOAD_EN
//   defined   : RELOAD lasts RELOAD_CYCLES cycles (down-counter), fire is
//               ignored while reloading, exit goes to SHOT only if the fire
//               key is present, otherwise to PLAY_WAIT.
//   undefined : RELOAD lasts one cycle and always continues with shot 1.
//
// Ports
//   clk                 in   system clock, rising edge
//   reset               in   synchronous, active-low reset
//   player              in   selects FIRE_KEY_P0 (0) or FIRE_KEY_P1 (1)
//   collision           in   player hit, level-sensitive
//   counter_sum   [3:0] in   current score
//   keycode  [8*KS-1:0] in   keycode report, slot k = bits [8k+7:8k]
//   bullet_num    [3:0] out  active shot number, 0 when no shot is active
//   bullet_status [NB]  out  one-hot of the shot in flight
//   bullet_fire         out  one-cycle pulse on the first cycle of a shot
//   start_game          out  high in the play states, HIT and DONE
//   start_enemy_bullets out  high in ARM
//   finish_game         out  high in DONE
//   hold_count    [3:0] out  HIT counter, 0 outside HIT
// ---------------------------------------------------------------------------
module game_ctrl_multi #(
    parameter int         NUM_BULLETS   = 6,
    parameter int         KEY_SLOTS     = 6,
    parameter int         SCORE_LIMIT   = 10,
    parameter int         HIT_HOLD      = 10,
    parameter int         RELOAD_CYCLES = 32,
    parameter logic [7:0] START_KEY     = 8'd40,
    parameter logic [7:0] FIRE_KEY_P0   = 8'h05,
    parameter logic [7:0] FIRE_KEY_P1   = 8'h34
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   player,
    input  logic                   collision,
    input  logic [3:0]             counter_sum,
    input  logic [8*KEY_SLOTS-1:0] keycode,
    output logic [3:0]             bullet_num,
    output logic [NUM_BULLETS-1:0] bullet_status,
    output logic                   bullet_fire,
    output logic                   start_game,
    output logic                   start_enemy_bullets,
    output logic                   finish_game,
    output logic [3:0]             hold_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARM,
        S_PLAY_WAIT,
        S_SHOT,
        S_SHOT_HELD,
        S_SHOT_REL,
        S_RELOAD,
        S_HIT,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_SHOT = 4'(NUM_BULLETS);
    localparam logic [3:0] HOLD_LAST = 4'(HIT_HOLD - 1);

    // Illegal parameter combinations stop elaboration instead of building
    // a controller whose 4-bit shot numbers cannot represent the magazine.
    if (NUM_BULLETS < 1 || NUM_BULLETS > 15 || RELOAD_CYCLES < 1) begin : g_param_check
        $error("game_ctrl_multi: NUM_BULLETS must be 1..15 and RELOAD_CYCLES >= 1");
    end

    state_t                 state;
    state_t                 state_nx;
    logic [3:0]             index;
    logic [3:0]             index_nx;
    logic [3:0]             hold_nx;
    logic [NUM_BULLETS-1:0] onehot_nx;
    logic [7:0]             fire_key;
    logic                   start_hit;
    logic                   fire_hit;
    logic                   score_hit;

`ifdef GAME_CTRL_RELOAD_EN
    localparam int              RW          = $clog2(RELOAD_CYCLES + 1);
    localparam logic [RW-1:0]   RELOAD_LOAD = RW'(RELOAD_CYCLES);
    logic [RW-1:0]              reload_cnt;
    logic [RW-1:0]              reload_nx;
`endif

    // Scan every keycode slot for the start key and the active player's
    // fire key; a key anywhere in the report counts as pressed.
    always_comb begin
        fire_key  = player ? FIRE_KEY_P1 : FIRE_KEY_P0;
        start_hit = 1'b0;
        fire_hit  = 1'b0;
        for (int k = 0; k < KEY_SLOTS; k++) begin
            if (keycode[8*k +: 8] == START_KEY) start_hit = 1'b1;
            if (keycode[8*k +: 8] == fire_key)  fire_hit  = 1'b1;
        end
    end

    // Score reached: both sides widened so a limit above 15 simply never fires.
    assign score_hit = (32'(counter_sum) >= 32'(SCORE_LIMIT));

    // Next-state logic. In the play states the score override beats the
    // collision override, which beats the normal transition. RELOAD does
    // not react to collision, and HIT only reacts to the score.
    always_comb begin
        state_nx = state;
        index_nx = index;
        hold_nx  = 4'd0;
`ifdef GAME_CTRL_RELOAD_EN
        reload_nx = '0;
`endif
        case (state)
            S_IDLE: begin
                if (start_hit) state_nx = S_ARM;
            end
            S_ARM: begin
                if (!start_hit) state_nx = S_PLAY_WAIT;
            end
            S_PLAY_WAIT, S_SHOT, S_SHOT_HELD, S_SHOT_REL, S_RELOAD: begin
                if (score_hit) begin
                    state_nx = S_DONE;
                end else if (collision && state != S_RELOAD) begin
                    state_nx = S_HIT;
                end else begin
                    case (state)
                        S_PLAY_WAIT: begin
                            if (fire_hit) begin
                                state_nx = S_SHOT;
                                index_nx = 4'd1;
                            end
                        end
                        S_SHOT: begin
                            state_nx = S_SHOT_HELD;
                        end
                        S_SHOT_HELD: begin
                            if (!fire_hit) state_nx = S_SHOT_REL;
                        end
                        S_SHOT_REL: begin
                            if (fire_hit) begin
                                if (index < LAST_SHOT) begin
                                    state_nx = S_SHOT;
                                    index_nx = index + 4'd1;
                                end else begin
                                    state_nx = S_RELOAD;
                                end
                            end
                        end
                        S_RELOAD: begin
`ifdef GAME_CTRL_RELOAD_EN
                            if (reload_cnt <= RW'(1)) begin
                                state_nx = fire_hit ? S_SHOT : S_PLAY_WAIT;
                                index_nx = 4'd1;
                            end else begin
                                reload_nx = reload_cnt - RW'(1);
                            end
`else
                            state_nx = S_SHOT;
                            index_nx = 4'd1;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            S_HIT: begin
                if (score_hit || hold_count == HOLD_LAST) begin
                    state_nx = S_DONE;
                end else begin
                    hold_nx = (hold_count == 4'hF) ? hold_count : hold_count + 4'd1;
                end
            end
            S_DONE: begin
                if (start_hit) state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

`ifdef GAME_CTRL_RELOAD_EN
        // The reload timer is armed only on the edge that enters RELOAD.
        if (state_nx == S_RELOAD && state != S_RELOAD) reload_nx = RELOAD_LOAD;
`endif

        // The shot index only has meaning while a magazine is in use.
        if (!(state_nx inside {S_SHOT, S_SHOT_HELD, S_SHOT_REL, S_RELOAD})) index_nx = 4'd0;
    end

    // One-hot image of the next shot index for bullet_status.
    always_comb begin
        onehot_nx = '0;
        for (int n = 0; n < NUM_BULLETS; n++) begin
            onehot_nx[n] = (index_nx == 4'(n + 1));
        end
    end

    // State, counters and all outputs are registered together, so every
    // output is a clean Moore decode of the state entered on this edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state               <= S_IDLE;
            index               <= 4'd0;
            hold_count          <= 4'd0;
            bullet_num          <= 4'd0;
            bullet_status       <= '0;
            bullet_fire         <= 1'b0;
            start_game          <= 1'b0;
            start_enemy_bullets <= 1'b0;
            finish_game         <= 1'b0;
`ifdef GAME_CTRL_RELOAD_EN
            reload_cnt          <= '0;
`endif
        end else begin
            state               <= state_nx;
            index               <= index_nx;
            hold_count          <= hold_nx;
            bullet_num          <= (state_nx inside {S_SHOT, S_SHOT_HELD, S_SHOT_REL}) ? index_nx : 4'd0;
            bullet_status       <= (state_nx inside {S_SHOT, S_SHOT_HELD}) ? onehot_nx : '0;
            bullet_fire         <= (state_nx == S_SHOT);
            start_game          <= (state_nx inside {S_PLAY_WAIT, S_SHOT, S_SHOT_HELD, S_SHOT_REL,
                                                     S_RELOAD, S_HIT, S_DONE});
            start_enemy_bullets <= (state_nx == S_ARM);
            finish_game         <= (state_nx == S_DONE);
`ifdef GAME_CTRL_RELOAD_EN
            reload_cnt          <= reload_nx;
`endif
        end
    end

endmodule

// File: tb/tb_game_ctrl_multi.sv
// ---------------------------------------------------------------------------
// tb_game_ctrl_multi
//
// Self-checking bench for game_ctrl_multi with default parameters. Each
// scenario task builds a table of input rows with the outputs expected
// after the next rising edge; the expectation is pushed to a scoreboard
// queue as the row is driven and popped/compared once the edge has passed.
// ---------------------------------------------------------------------------
module tb_game_ctrl_multi;

`ifdef GAME_CTRL_RELOAD_EN
    localparam int RELOAD_ROWS = 32;
`else
    localparam int RELOAD_ROWS = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        player;
    logic        collision;
    logic [3:0]  counter_sum;
    logic [47:0] keycode;
    logic [3:0]  bullet_num;
    logic [5:0]  bullet_status;
    logic        bullet_fire;
    logic        start_game;
    logic        start_enemy_bullets;
    logic        finish_game;
    logic [3:0]  hold_count;

    typedef struct packed {
        logic [3:0] num;
        logic [5:0] status;
        logic       fire;
        logic       sg;
        logic       seb;
        logic       fg;
        logic [3:0] hc;
    } out_t;

    typedef struct packed {
        logic       rst_n;
        logic       start;
        logic       fire;
        logic       wrong;
        logic       coll;
        logic [3:0] score;
        out_t       exp;
    } row_t;

    out_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   fire_slot = 0;

    game_ctrl_multi #(
        .NUM_BULLETS  (6),
        .KEY_SLOTS    (6),
        .SCORE_LIMIT  (10),
        .HIT_HOLD     (10),
        .RELOAD_CYCLES(32),
        .START_KEY    (8'd40),
        .FIRE_KEY_P0  (8'h05),
        .FIRE_KEY_P1  (8'h34)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .player             (player),
        .collision          (collision),
        .counter_sum        (counter_sum),
        .keycode            (keycode),
        .bullet_num         (bullet_num),
        .bullet_status      (bullet_status),
        .bullet_fire        (bullet_fire),
        .start_game         (start_game),
        .start_enemy_bullets(start_enemy_bullets),
        .finish_game        (finish_game),
        .hold_count         (hold_count)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required summary before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected-output builders.
    function automatic out_t mk(int num, bit st, bit fire, bit sg, bit seb, bit fg, int hc);
        out_t       o;
        logic [5:0] one;
        one      = 6'b000001;
        o.num    = 4'(num);
        o.status = st ? (one << (num - 1)) : 6'b0;
        o.fire   = fire;
        o.sg     = sg;
        o.seb    = seb;
        o.fg     = fg;
        o.hc     = 4'(hc);
        return o;
    endfunction

    function automatic out_t o_idle();       return mk(0, 0, 0, 0, 0, 0, 0); endfunction
    function automatic out_t o_arm();        return mk(0, 0, 0, 0, 1, 0, 0); endfunction
    function automatic out_t o_play();       return mk(0, 0, 0, 1, 0, 0, 0); endfunction
    function automatic out_t o_shot(int n);  return mk(n, 1, 1, 1, 0, 0, 0); endfunction
    function automatic out_t o_held(int n);  return mk(n, 1, 0, 1, 0, 0, 0); endfunction
    function automatic out_t o_rel(int n);   return mk(n, 0, 0, 1, 0, 0, 0); endfunction
    function automatic out_t o_hit(int h);   return mk(0, 0, 0, 1, 0, 0, h); endfunction
    function automatic out_t o_done();       return mk(0, 0, 0, 1, 0, 1, 0); endfunction

    // Row builders: full form, and the common "reset high, no collision, score 0" form.
    function automatic row_t rw(bit rst_n, bit start, bit fire, bit wrong, bit coll, int score, out_t exp);
        row_t r;
        r.rst_n = rst_n;
        r.start = start;
        r.fire  = fire;
        r.wrong = wrong;
        r.coll  = coll;
        r.score = 4'(score);
        r.exp   = exp;
        return r;
    endfunction

    function automatic row_t kr(bit start, bit fire, out_t exp);
        return rw(1, start, fire, 0, 0, 0, exp);
    endfunction

    function automatic out_t observe();
        out_t o;
        o.num    = bullet_num;
        o.status = bullet_status;
        o.fire   = bullet_fire;
        o.sg     = start_game;
        o.seb    = start_enemy_bullets;
        o.fg     = finish_game;
        o.hc     = hold_count;
        return o;
    endfunction

    function automatic string fmt(out_t o);
        return $sformatf("num=%0d status=%b fire=%b start_game=%b enemy=%b finish=%b hold=%0d",
                         o.num, o.status, o.fire, o.sg, o.seb, o.fg, o.hc);
    endfunction

    // Apply one row of inputs. The fire key goes in fire_slot; the start key
    // goes in a different slot. 'wrong' places the other player's fire key.
    task automatic drive(row_t r);
        int ss;
        ss          = (fire_slot == 0) ? 1 : 0;
        reset       = r.rst_n;
        collision   = r.coll;
        counter_sum = r.score;
        keycode     = '0;
        if (r.start) keycode[ss*8 +: 8] = 8'd40;
        if (r.fire)  keycode[fire_slot*8 +: 8] = (player ^ r.wrong) ? 8'h34 : 8'h05;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t rows[$];
        out_t a, e;
        player    = 1'b0;
        fire_slot = 0;
        rows.push_back(rw(0, 0, 0, 0, 0, 0, o_idle()));
        rows.push_back(rw(0, 1, 0, 0, 0, 0, o_idle()));
        rows.push_back(kr(0, 0, o_idle()));
        rows.push_back(kr(0, 0, o_idle()));
        foreach (rows[i]) begin
            drive(rows[i]);
            sb.push_back(rows[i].exp);
            tick();
            a = observe();
            e = sb.pop_front();
            checks++;
            if (a !== e) begin
                failures++;
                $display("[TB] FAIL reset[%0d]: got %s, expected %s", i, fmt(a), fmt(e));
            end
        end
    endtask

    task automatic test_start_fire();
        row_t rows[$];
        out_t a, e;
        player    = 1'b0;
        fire_slot = 0;
        rows.push_back(kr(1, 0, o_arm()));
        rows.push_back(kr(1, 0, o_arm()));
        rows.push_back(kr(1, 0, o_arm()));
        rows.push_back(kr(0, 0, o_play()));
        rows.push_back(kr(0, 1, o_shot(1)));
        rows.push_back(kr(0, 1, o_held(1)));
        rows.push_back(kr(0, 1, o_held(1)));
        rows.push_back(kr(0, 0, o_rel(1)));
        rows.push_back(rw(1, 0, 0, 0, 0, 9, o_rel(1)));
        foreach (rows[i]) begin
            drive(rows[i]);
            sb.push_back(rows[i].exp);
            tick();
            a = observe();
            e = sb.pop_front();
            checks++;
            if (a !== e) begin
                failures++;
                $display("[TB] FAIL start_fire[%0d]: got %s, expected %s", i, fmt(a), fmt(e));
            end
        end
    endtask

    task automatic test_magazine();
        row_t rows[$];
        out_t a, e;
        player    = 1'b1;
        fire_slot = 5;
        rows.push_back(rw(0, 0, 0, 0, 0, 0, o_idle()));
        rows.push_back(kr(1, 0, o_arm()));
        rows.push_back(kr(0, 0, o_play()));
        rows.push_back(rw(1, 0, 1, 1, 0, 0, o_play()));
        for (int n = 1; n <= 6; n++) begin
            rows.push_back(kr(0, 1, o_shot(n)));
            rows.push_back(kr(0, 1, o_held(n)));
            rows.push_back(kr(0, 0, o_rel(n)));
        end
        for (int k = 0; k < RELOAD_ROWS; k++) rows.push_back(kr(0, 1, o_play()));
        rows.push_back(kr(0, 1, o_shot(1)));
        rows.push_back(kr(0, 1, o_held(1)));
        rows.push_back(kr(0, 0, o_rel(1)));
        foreach (rows[i]) begin
            drive(rows[i]);
            sb.push_back(rows[i].exp);
            tick();
            a = observe();
            e = sb.pop_front();
            checks++;
            if (a !== e) begin
                failures++;
                $display("[TB] FAIL magazine[%0d]: got %s, expected %s", i, fmt(a), fmt(e));
            end
        end
    endtask

    task automatic test_hit_hold();
        row_t rows[$];
        out_t a, e;
        rows.push_back(kr(0, 1, o_shot(2)));
        rows.push_back(kr(0, 1, o_held(2)));
        rows.push_back(rw(1, 0, 1, 0, 1, 0, o_hit(0)));
        rows.push_back(rw(1, 0, 0, 0, 1, 0, o_hit(1)));
        for (int h = 2; h <= 9; h++) rows.push_back(kr(0, 0, o_hit(h)));
        rows.push_back(kr(0, 0, o_done()));
        rows.push_back(kr(0, 0, o_done()));
        rows.push_back(kr(1, 0, o_idle()));
        rows.push_back(kr(1, 0, o_arm()));
        rows.push_back(kr(0, 0, o_play()));
        foreach (rows[i]) begin
            drive(rows[i]);
            sb.push_back(rows[i].exp);
            tick();
            a = observe();
            e = sb.pop_front();
            checks++;
            if (a !== e) begin
                failures++;
                $display("[TB] FAIL hit_hold[%0d]: got %s, expected %s", i, fmt(a), fmt(e));
            end
        end
    endtask

    task automatic test_score_collision();
        row_t rows[$];
        out_t a, e;
        rows.push_back(rw(1, 0, 0, 0, 0, 9, o_play()));
        rows.push_back(kr(0, 1, o_shot(1)));
        rows.push_back(kr(0, 1, o_held(1)));
        rows.push_back(kr(0, 0, o_rel(1)));
        rows.push_back(rw(1, 0, 1, 0, 1, 10, o_done()));
        rows.push_back(rw(1, 0, 0, 0, 0, 10, o_done()));
        rows.push_back(kr(1, 0, o_idle()));
        rows.push_back(kr(0, 0, o_idle()));
        rows.push_back(kr(1, 0, o_arm()));
        rows.push_back(kr(0, 0, o_play()));
        rows.push_back(kr(0, 1, o_shot(1)));
        rows.push_back(kr(0, 1, o_held(1)));
        rows.push_back(kr(0, 0, o_rel(1)));
        rows.push_back(rw(1, 0, 1, 0, 1, 0, o_hit(0)));
        rows.push_back(rw(1, 0, 0, 0, 0, 9, o_hit(1)));
        rows.push_back(rw(1, 0, 0, 0, 0, 15, o_done()));
        rows.push_back(kr(1, 0, o_idle()));
        rows.push_back(kr(1, 0, o_arm()));
        rows.push_back(kr(0, 0, o_play()));
        foreach (rows[i]) begin
            drive(rows[i]);
            sb.push_back(rows[i].exp);
            tick();
            a = observe();
            e = sb.pop_front();
            checks++;
            if (a !== e) begin
                failures++;
                $display("[TB] FAIL score_collision[%0d]: got %s, expected %s", i, fmt(a), fmt(e));
            end
        end
    endtask

    task automatic test_reset_mid_game();
        row_t rows[$];
        out_t a, e;
        for (int n = 1; n <= 3; n++) begin
            rows.push_back(kr(0, 1, o_shot(n)));
            rows.push_back(kr(0, 1, o_held(n)));
            rows.push_back(kr(0, 0, o_rel(n)));
        end
        rows.push_back(kr(0, 1, o_shot(4)));
        rows.push_back(kr(0, 1, o_held(4)));
        rows.push_back(rw(0, 0, 1, 0, 0, 0, o_idle()));
        rows.push_back(kr(0, 1, o_idle()));
        rows.push_back(kr(0, 0, o_idle()));
        rows.push_back(kr(1, 0, o_arm()));
        rows.push_back(kr(0, 0, o_play()));
        rows.push_back(kr(0, 1, o_shot(1)));
        rows.push_back(kr(0, 0, o_held(1)));
        rows.push_back(kr(0, 0, o_rel(1)));
        foreach (rows[i]) begin
            drive(rows[i]);
            sb.push_back(rows[i].exp);
            tick();
            a = observe();
            e = sb.pop_front();
            checks++;
            if (a !== e) begin
                failures++;
                $display("[TB] FAIL reset_mid_game[%0d]: got %s, expected %s", i, fmt(a), fmt(e));
            end
        end
    endtask

    initial begin
        reset       = 1'b0;
        player      = 1'b0;
        collision   = 1'b0;
        counter_sum = 4'd0;
        keycode     = '0;
        test_reset();
        test_start_fire();
        test_magazine();
        test_hit_hold();
        test_score_collision();
        test_reset_mid_game();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
